// File: rtl/imem_arbiter.sv
// Round-robin arbiter that multiplexes NCPU icache fill requests onto one RAM read port.
// The grant is held until the fill completes. It is dropped early if the requester withdraws
// its request or changes its address.
module imem_arbiter #(
  parameter int unsigned NCPU = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCPU-1:0]      iREN,
  input  logic [NCPU-1:0][31:0] iaddr,
  output logic [NCPU-1:0]      iwait,
  output logic [NCPU-1:0][31:0] iload,
  output logic                 ram_ren,
  output logic [31:0]          ram_addr,
  input  logic [31:0]          ram_load,
  input  logic                 ram_ready
);

  localparam int unsigned GW = (NCPU > 1) ? $clog2(NCPU) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [GW-1:0] r_grant, w_grant_nxt;
  logic [GW-1:0] r_last,  w_last_nxt;
  logic [31:0]   r_addr,  w_addr_nxt;

  logic          w_any;
  logic [GW-1:0] w_pick;
  logic          w_hold;

  // Round-robin pick: first requester at distance 1..NCPU from the last served CPU
  always_comb begin
    int unsigned v_idx;
    w_any  = 1'b0;
    w_pick = '0;
    v_idx  = 0;
    for (int unsigned k = 1; k <= NCPU; k++) begin
      v_idx = (32'(r_last) + k) % NCPU;
      if (!w_any && iREN[GW'(v_idx)]) begin
        w_any  = 1'b1;
        w_pick = GW'(v_idx);
      end
    end
  end

  // The granted requester still wants the same word that is in flight
  assign w_hold = iREN[r_grant] && (iaddr[r_grant] == r_addr);

  // Next-state and per-CPU return path; completion data is forwarded in the ready cycle
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_addr_nxt  = r_addr;
    iwait       = '1;
    iload       = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_addr_nxt  = iaddr[w_pick];
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!w_hold) begin
          w_last_nxt  = r_grant;
          w_state_nxt = IDLE;
        end else if (ram_ready) begin
          iwait[r_grant] = 1'b0;
          iload[r_grant] = ram_load;
          w_last_nxt     = r_grant;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset leaves CPU0 as the first winner
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= GW'(NCPU - 1);
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign ram_ren  = (r_state == ACCESS);
  assign ram_addr = r_addr;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter (NCPU=2): vector table plus scoreboarded fill streams.
module tb_imem_arbiter;

  logic             CLK = 1'b0;
  logic             RST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic             ram_ren;
  logic [31:0]      ram_addr;
  logic [31:0]      ram_load;
  logic             ram_ready;

  logic             auto_ram;
  logic             man_ready;
  logic [31:0]      man_load;

  int n_total = 0;
  int n_pass  = 0;

  imem_arbiter #(.NCPU(2)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ram_ren(ram_ren), .ram_addr(ram_addr), .ram_load(ram_load), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ram_model(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hA5A5_0000;
  endfunction

  // RAM model: answers in the same cycle ram_ren is raised when in auto mode
  assign ram_ready = auto_ram ? ram_ren : man_ready;
  assign ram_load  = auto_ram ? ram_model(ram_addr) : man_load;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  ren;
    logic [31:0] a0, a1;
    logic        rdy;
    logic [31:0] load;
    logic        e_ren;
    logic [31:0] e_addr;
    logic [1:0]  e_wait;
    logic [31:0] e_l0, e_l1;
  } vec_t;

  typedef struct {
    int          cpu;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  vec_t vt[18];
  exp_t sb[$];

  // Drives both CPUs with auto RAM; checks each completion against the scoreboard head
  task automatic run_auto(input logic [1:0] req, input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] step, input int n);
    int served0 = 0;
    int done = 0;
    int last_t = -1;
    int cyc = 0;
    exp_t e;
    @(posedge CLK); #1;
    iREN = req; iaddr[0] = b0; iaddr[1] = b1;
    while (done < n && cyc < 80) begin
      @(negedge CLK);
      cyc++;
      if (iwait != 2'b11) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_iwait", 32'(iwait), (e.cpu == 0) ? 32'h2 : 32'h1);
          chk("done_ram_addr", ram_addr, e.addr);
          chk("done_iload", iload[e.cpu], e.data);
          chk("idle_iload", iload[1 - e.cpu], 32'h0);
          if (last_t >= 0) chk("fill_spacing", 32'(cyc - last_t), 32'd2);
        end
        if (iwait[0] == 1'b0) served0++;
        last_t = cyc;
        done++;
      end else if (last_t == cyc - 1) begin
        chk("bubble_ren", 32'(ram_ren), 32'd0);
      end
      @(posedge CLK); #1;
      iaddr[0] = b0 + step * 32'(served0);
      if (done == n) iREN = 2'b00;
    end
    chk("fills_done", 32'(done), 32'(n));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    RST = 1'b1; iREN = '0; iaddr = '0; auto_ram = 1'b0; man_ready = 1'b0; man_load = '0;

    //  rst ren  a0            a1            rdy  load           e_ren e_addr        e_wait e_l0           e_l1
    vt[0]  = '{1, 2'b00, 32'h0,   32'h0,   0, 32'h0,        0, 32'h0,   2'b11, 32'h0,        32'h0};
    vt[1]  = '{0, 2'b01, 32'h40,  32'h0,   0, 32'h0,        0, 32'h0,   2'b11, 32'h0,        32'h0};
    vt[2]  = '{0, 2'b01, 32'h40,  32'h0,   0, 32'h0,        1, 32'h40,  2'b11, 32'h0,        32'h0};
    vt[3]  = '{0, 2'b01, 32'h40,  32'h0,   0, 32'h0,        1, 32'h40,  2'b11, 32'h0,        32'h0};
    vt[4]  = '{0, 2'b01, 32'h40,  32'h0,   1, 32'hDEADBEEF, 1, 32'h40,  2'b10, 32'hDEADBEEF, 32'h0};
    vt[5]  = '{0, 2'b00, 32'h40,  32'h0,   1, 32'hDEADBEEF, 0, 32'h40,  2'b11, 32'h0,        32'h0};
    vt[6]  = '{0, 2'b10, 32'h40,  32'h200, 0, 32'h0,        0, 32'h40,  2'b11, 32'h0,        32'h0};
    vt[7]  = '{0, 2'b10, 32'h40,  32'h200, 0, 32'h0,        1, 32'h200, 2'b11, 32'h0,        32'h0};
    vt[8]  = '{0, 2'b10, 32'h40,  32'h300, 1, 32'h1234,     1, 32'h200, 2'b11, 32'h0,        32'h0};
    vt[9]  = '{0, 2'b11, 32'h80,  32'h300, 0, 32'h0,        0, 32'h200, 2'b11, 32'h0,        32'h0};
    vt[10] = '{0, 2'b11, 32'h80,  32'h300, 0, 32'h0,        1, 32'h80,  2'b11, 32'h0,        32'h0};
    vt[11] = '{0, 2'b11, 32'h80,  32'h300, 1, 32'h5555,     1, 32'h80,  2'b10, 32'h5555,     32'h0};
    vt[12] = '{0, 2'b10, 32'h80,  32'h300, 0, 32'h0,        0, 32'h80,  2'b11, 32'h0,        32'h0};
    vt[13] = '{0, 2'b10, 32'h80,  32'h300, 1, 32'h6666,     1, 32'h300, 2'b01, 32'h0,        32'h6666};
    vt[14] = '{0, 2'b00, 32'h80,  32'h300, 0, 32'h0,        0, 32'h300, 2'b11, 32'h0,        32'h0};
    vt[15] = '{0, 2'b01, 32'h44,  32'h300, 0, 32'h0,        0, 32'h300, 2'b11, 32'h0,        32'h0};
    vt[16] = '{0, 2'b00, 32'h44,  32'h300, 1, 32'h7777,     1, 32'h44,  2'b11, 32'h0,        32'h0};
    vt[17] = '{0, 2'b00, 32'h44,  32'h300, 0, 32'h0,        0, 32'h44,  2'b11, 32'h0,        32'h0};

    for (int i = 0; i < 18; i++) begin
      @(posedge CLK); #1;
      RST = vt[i].rst; iREN = vt[i].ren; iaddr[0] = vt[i].a0; iaddr[1] = vt[i].a1;
      man_ready = vt[i].rdy; man_load = vt[i].load;
      @(negedge CLK);
      chk($sformatf("v%0d_ram_ren", i), 32'(ram_ren), 32'(vt[i].e_ren));
      chk($sformatf("v%0d_ram_addr", i), ram_addr, vt[i].e_addr);
      chk($sformatf("v%0d_iwait", i), 32'(iwait), 32'(vt[i].e_wait));
      chk($sformatf("v%0d_iload0", i), iload[0], vt[i].e_l0);
      chk($sformatf("v%0d_iload1", i), iload[1], vt[i].e_l1);
    end

    // Async reset in the middle of an access, with no clock edge in between
    @(posedge CLK); #1;
    iREN = 2'b01; iaddr[0] = 32'h48; man_ready = 1'b0;
    @(posedge CLK); #1;
    man_ready = 1'b1; man_load = 32'hCAFE_F00D;
    chk("pre_rst_ren", 32'(ram_ren), 32'd1);
    #1;
    RST = 1'b1;
    #1;
    chk("async_rst_ren", 32'(ram_ren), 32'd0);
    chk("async_rst_iwait", 32'(iwait), 32'h3);
    chk("async_rst_iload0", iload[0], 32'h0);
    chk("async_rst_iload1", iload[1], 32'h0);
    chk("async_rst_addr", ram_addr, 32'h0);
    iREN = 2'b00; man_ready = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    auto_ram = 1'b1;

    // Both CPUs requesting from reset: CPU0 first, then strict alternation
    for (int r = 0; r < 5; r++) begin
      sb.push_back('{0, 32'h100, ram_model(32'h100)});
      sb.push_back('{1, 32'h200, ram_model(32'h200)});
    end
    run_auto(2'b11, 32'h100, 32'h200, 32'h0, 10);

    // CPU0 streaming sequential words
    @(posedge CLK); #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    for (int k = 0; k < 8; k++)
      sb.push_back('{0, 32'h1000 + 32'(4 * k), ram_model(32'h1000 + 32'(4 * k))});
    run_auto(2'b01, 32'h1000, 32'h0, 32'h4, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
